// File: rtl/run_event_logger_pkg.sv
// Shared definitions for the run event logger: FSM state encoding, display
// select codes and the counter saturation limit.
package run_event_logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN0 = 2'd1,
    ST_RUN1 = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_CNT0 = 2'b00;
  localparam logic [1:0] SEL_CNT1 = 2'b01;
  localparam logic [1:0] SEL_MAX  = 2'b10;
  localparam logic [1:0] SEL_RUN  = 2'b11;

  // All-ones value of a counter of the given width (the saturation point).
  function automatic logic [31:0] sat_limit(input int unsigned width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/run_event_logger_hex7seg.sv
// Hex digit to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/run_event_logger.sv
// Statistics logger for the run detector: counts zero/one run events, tracks the
// current and longest run length, flags illegal flag combinations, and drives two hex digits.
module run_event_logger
  import run_event_logger_pkg::*;
#(
  parameter int COUNT_W   = 8,
  parameter int RUN_START = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_run0,
  input  logic               in_run1,
  input  logic               clear,
  input  logic [1:0]         sel,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1,
  output logic [COUNT_W-1:0] run_len,
  output logic [COUNT_W-1:0] max_len,
  output logic               err,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1
);

  localparam logic [COUNT_W-1:0] SAT_MAX   = COUNT_W'(sat_limit(COUNT_W));
  localparam logic [COUNT_W-1:0] LEN_START = COUNT_W'(RUN_START);
  localparam logic [COUNT_W-1:0] ONE       = COUNT_W'(1);

  state_e             state_reg, state_next;
  logic [COUNT_W-1:0] cnt0_reg, cnt0_next;
  logic [COUNT_W-1:0] cnt1_reg, cnt1_next;
  logic [COUNT_W-1:0] run_len_reg, run_len_next;
  logic [COUNT_W-1:0] max_len_reg, max_len_next;
  logic               wipe;

  assign wipe = !reset || clear;

  always_comb begin
    state_next = state_reg;
    if (state_reg != ST_ERR) begin
      if (in_run0 && in_run1) state_next = ST_ERR;
      else if (in_run0)       state_next = ST_RUN0;
      else if (in_run1)       state_next = ST_RUN1;
      else                    state_next = ST_IDLE;
    end
  end

  always_comb begin
    cnt0_next    = cnt0_reg;
    cnt1_next    = cnt1_reg;
    run_len_next = '0;
    max_len_next = max_len_reg;

    if (state_next == ST_RUN0 && state_reg != ST_RUN0 && cnt0_reg != SAT_MAX)
      cnt0_next = cnt0_reg + ONE;
    if (state_next == ST_RUN1 && state_reg != ST_RUN1 && cnt1_reg != SAT_MAX)
      cnt1_next = cnt1_reg + ONE;

    // A flip between RUN0 and RUN1 is a fresh run, so only staying put extends the length.
    if (state_next == ST_RUN0 || state_next == ST_RUN1) begin
      if (state_next == state_reg)
        run_len_next = (run_len_reg == SAT_MAX) ? run_len_reg : run_len_reg + ONE;
      else
        run_len_next = LEN_START;
    end

    if (run_len_next > max_len_reg) max_len_next = run_len_next;
  end

  always_ff @(posedge clock) begin
    if (wipe) begin
      state_reg   <= ST_IDLE;
      cnt0_reg    <= '0;
      cnt1_reg    <= '0;
      run_len_reg <= '0;
      max_len_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt0_reg    <= cnt0_next;
      cnt1_reg    <= cnt1_next;
      run_len_reg <= run_len_next;
      max_len_reg <= max_len_next;
    end
  end

  assign cnt0    = cnt0_reg;
  assign cnt1    = cnt1_reg;
  assign run_len = run_len_reg;
  assign max_len = max_len_reg;
  assign err     = (state_reg == ST_ERR);

  logic [COUNT_W-1:0]   sel_value;
  logic [COUNT_W+7:0]   sel_ext;
  logic [7:0]           disp_byte;
  logic [1:0][6:0]      hex_bus;

  always_comb begin
    sel_value = cnt0_reg;
    case (sel)
      SEL_CNT0: sel_value = cnt0_reg;
      SEL_CNT1: sel_value = cnt1_reg;
      SEL_MAX:  sel_value = max_len_reg;
      SEL_RUN:  sel_value = run_len_reg;
      default:  sel_value = cnt0_reg;
    endcase
  end

  // Blank to digit 0 while a wipe is pending, not only once the registers have cleared.
  assign sel_ext   = {8'h00, sel_value};
  assign disp_byte = wipe ? 8'h00 : sel_ext[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hex
      hex7seg u_hex7seg (
        .digit (disp_byte[gi*4 +: 4]),
        .seg   (hex_bus[gi])
      );
    end
  endgenerate

  assign hex0 = hex_bus[0];
  assign hex1 = hex_bus[1];

endmodule

// File: tb/tb_run_event_logger.sv
// Self-checking bench for run_event_logger: directed scenarios plus a randomized
// run against an event-level reference model.
module tb_run_event_logger;

  localparam int CW     = 8;
  localparam int RSTART = 4;
  localparam int SAT    = 255;

  logic          clock;
  logic          reset;
  logic          in_run0;
  logic          in_run1;
  logic          clear;
  logic [1:0]    sel;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] run_len;
  logic [CW-1:0] max_len;
  logic          err;
  logic [6:0]    hex0;
  logic [6:0]    hex1;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: which run we are in (-1 none), how long it has lasted, event counts.
  int m_kind = -1;
  int m_age  = 0;
  int m_cnt0 = 0;
  int m_cnt1 = 0;
  int m_len  = 0;
  int m_max  = 0;
  int m_err  = 0;

  run_event_logger #(.COUNT_W(CW), .RUN_START(RSTART)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_run0 (in_run0),
    .in_run1 (in_run1),
    .clear   (clear),
    .sel     (sel),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .run_len (run_len),
    .max_len (max_len),
    .err     (err),
    .hex0    (hex0),
    .hex1    (hex1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input int d);
    case (d & 15)
      0:  return 7'b1000000;  1:  return 7'b1111001;
      2:  return 7'b0100100;  3:  return 7'b0110000;
      4:  return 7'b0011001;  5:  return 7'b0010010;
      6:  return 7'b0000010;  7:  return 7'b1111000;
      8:  return 7'b0000000;  9:  return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int min_sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_update(input logic r0, input logic r1, input logic clr, input logic rst_n);
    int k;
    if (!rst_n || clr) begin
      m_kind = -1; m_age = 0; m_cnt0 = 0; m_cnt1 = 0; m_len = 0; m_max = 0; m_err = 0;
    end else if (m_err != 0) begin
      // error is absorbing: nothing changes
    end else if (r0 && r1) begin
      m_err = 1; m_kind = -1; m_len = 0;
    end else if (r0 || r1) begin
      k = r0 ? 0 : 1;
      if (m_kind == k) m_age++;
      else begin
        m_age = 0;
        if (k == 0) m_cnt0 = min_sat(m_cnt0 + 1);
        else        m_cnt1 = min_sat(m_cnt1 + 1);
      end
      m_kind = k;
      m_len  = min_sat(RSTART + m_age);
    end else begin
      m_kind = -1; m_len = 0;
    end
    if (m_len > m_max) m_max = m_len;
  endtask

  task automatic cyc(input logic r0, input logic r1, input logic clr, input logic rst_n);
    @(negedge clock);
    in_run0 = r0; in_run1 = r1; clear = clr; reset = rst_n;
    @(posedge clock);
    model_update(r0, r1, clr, rst_n);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    n_vec++;
    if (cnt0 !== 0 || cnt1 !== 0 || run_len !== 0 || max_len !== 0 || err !== 0) begin
      n_miss++;
      $display("FAIL reset_regs: got cnt0=%0d cnt1=%0d len=%0d max=%0d err=%0b, want all 0",
               cnt0, cnt1, run_len, max_len, err);
    end
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      n_vec++;
      if (hex0 !== 7'b1000000 || hex1 !== 7'b1000000) begin
        n_miss++;
        $display("FAIL reset_hex sel=%0d: got hex0=%b hex1=%b, want 1000000", s, hex0, hex1);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_run0_basic();
    int want[4] = '{4, 5, 6, 0};
    logic seq_r0[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(seq_r0[i], 0, 0, 1);
      n_vec++;
      if (run_len !== 8'(want[i])) begin
        n_miss++;
        $display("FAIL run0_len[%0d]: got %0d want %0d", i, run_len, want[i]);
      end
    end
    n_vec++;
    if (cnt0 !== 8'd1 || max_len !== 8'd6 || cnt1 !== 8'd0) begin
      n_miss++;
      $display("FAIL run0_totals: got cnt0=%0d max=%0d cnt1=%0d want 1 6 0", cnt0, max_len, cnt1);
    end
    $display("test_run0_basic done");
  endtask

  task automatic test_run1_pulses();
    int lens[3] = '{1, 2, 5};
    foreach (lens[p]) begin
      for (int c = 0; c < lens[p]; c++) cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
    end
    n_vec++;
    if (cnt1 !== 8'd3 || max_len !== 8'd8) begin
      n_miss++;
      $display("FAIL run1_totals: got cnt1=%0d max=%0d want 3 8", cnt1, max_len);
    end
    sel = 2'b01;
    #1;
    n_vec++;
    if (hex0 !== seg_of(3) || hex1 !== seg_of(0)) begin
      n_miss++;
      $display("FAIL run1_hex: got hex0=%b hex1=%b want %b %b", hex0, hex1, seg_of(3), seg_of(0));
    end
    $display("test_run1_pulses done");
  endtask

  task automatic test_switch();
    int want[3] = '{4, 5, 4};
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(i < 2, i == 2, 0, 1);
      n_vec++;
      if (run_len !== 8'(want[i])) begin
        n_miss++;
        $display("FAIL switch_len[%0d]: got %0d want %0d", i, run_len, want[i]);
      end
    end
    n_vec++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin
      n_miss++;
      $display("FAIL switch_cnt: got cnt0=%0d cnt1=%0d want 1 1", cnt0, cnt1);
    end
    $display("test_switch done");
  endtask

  task automatic test_error();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    n_vec++;
    if (err !== 1'b1 || cnt1 !== 8'd1 || cnt0 !== 8'd0 || run_len !== 8'd0 || max_len !== 8'd4) begin
      n_miss++;
      $display("FAIL err_entry: got err=%0b cnt0=%0d cnt1=%0d len=%0d max=%0d want 1 0 1 0 4",
               err, cnt0, cnt1, run_len, max_len);
    end
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    n_vec++;
    if (err !== 1'b1 || cnt0 !== 8'd0 || cnt1 !== 8'd1 || run_len !== 8'd0) begin
      n_miss++;
      $display("FAIL err_frozen: got err=%0b cnt0=%0d cnt1=%0d len=%0d want 1 0 1 0",
               err, cnt0, cnt1, run_len);
    end
    cyc(1, 1, 1, 1);
    n_vec++;
    if (err !== 1'b0 || cnt0 !== 0 || cnt1 !== 0 || run_len !== 0 || max_len !== 0) begin
      n_miss++;
      $display("FAIL err_clear: got err=%0b cnt0=%0d cnt1=%0d len=%0d max=%0d want all 0",
               err, cnt0, cnt1, run_len, max_len);
    end
    cyc(1, 0, 0, 1);
    n_vec++;
    if (cnt0 !== 8'd1 || run_len !== 8'd4 || err !== 1'b0) begin
      n_miss++;
      $display("FAIL err_after_clear: got cnt0=%0d len=%0d err=%0b want 1 4 0", cnt0, run_len, err);
    end
    $display("test_error done");
  endtask

  task automatic test_saturation();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
    end
    n_vec++;
    if (cnt0 !== 8'd255) begin
      n_miss++;
      $display("FAIL sat_cnt0: got %0d want 255", cnt0);
    end
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 1);
    n_vec++;
    if (run_len !== 8'd255 || max_len !== 8'd255 || cnt1 !== 8'd1) begin
      n_miss++;
      $display("FAIL sat_len: got len=%0d max=%0d cnt1=%0d want 255 255 1", run_len, max_len, cnt1);
    end
    $display("test_saturation done");
  endtask

  task automatic test_reset_midrun();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    sel = 2'b11;
    @(negedge clock);
    in_run0 = 1'b0; in_run1 = 1'b1; clear = 1'b0; reset = 1'b0;
    #1;
    n_vec++;
    if (hex0 !== seg_of(0) || hex1 !== seg_of(0)) begin
      n_miss++;
      $display("FAIL midrun_hex_blank: got hex0=%b hex1=%b want %b", hex0, hex1, seg_of(0));
    end
    @(posedge clock);
    model_update(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (cnt0 !== 0 || cnt1 !== 0 || run_len !== 0 || max_len !== 0 || err !== 0) begin
      n_miss++;
      $display("FAIL midrun_reset: got cnt0=%0d cnt1=%0d len=%0d max=%0d err=%0b want all 0",
               cnt0, cnt1, run_len, max_len, err);
    end
    cyc(0, 0, 0, 1);
    n_vec++;
    if (cnt1 !== 8'd0) begin
      n_miss++;
      $display("FAIL midrun_cnt1: got %0d want 0", cnt1);
    end
    $display("test_reset_midrun done");
  endtask

  task automatic test_random();
    logic r0, r1, clr, rst_n;
    int  roll, val;
    logic [6:0] e_hex0, e_hex1;
    r0 = 0; r1 = 0;
    for (int i = 0; i < 3000; i++) begin
      roll = int'($urandom_range(0, 99));
      if (roll < 4)       begin r0 = 1; r1 = 1; end
      else if (roll < 30) begin r0 = 1; r1 = 0; end
      else if (roll < 56) begin r0 = 0; r1 = 1; end
      else if (roll < 70) begin r0 = 0; r1 = 0; end
      // otherwise keep the previous flags so runs grow longer
      clr   = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      sel   = 2'($urandom_range(0, 3));
      cyc(r0, r1, clr, rst_n);
      case (sel)
        2'b00:   val = m_cnt0;
        2'b01:   val = m_cnt1;
        2'b10:   val = m_max;
        default: val = m_len;
      endcase
      if (!rst_n || clr) val = 0;
      e_hex0 = seg_of(val & 15);
      e_hex1 = seg_of((val >> 4) & 15);
      n_vec++;
      if (cnt0 !== 8'(m_cnt0) || cnt1 !== 8'(m_cnt1) || run_len !== 8'(m_len) ||
          max_len !== 8'(m_max) || err !== 1'(m_err) || hex0 !== e_hex0 || hex1 !== e_hex1) begin
        n_miss++;
        $display("FAIL random[%0d]: got c0=%0d c1=%0d len=%0d max=%0d err=%0b h=%b/%b want c0=%0d c1=%0d len=%0d max=%0d err=%0d h=%b/%b",
                 i, cnt0, cnt1, run_len, max_len, err, hex0, hex1,
                 m_cnt0, m_cnt1, m_len, m_max, m_err, e_hex0, e_hex1);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_run0 = 1'b0; in_run1 = 1'b0; sel = 2'b00;
    test_reset();
    test_run0_basic();
    test_run1_pulses();
    test_switch();
    test_error();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
